// File: rtl/fetch_sequencer_pkg.sv
// Shared types and default parameters for the instruction fetch/issue sequencer.
package fetch_sequencer_pkg;

    localparam int unsigned PcWDefault      = 16;
    localparam int unsigned OpcWDefault     = 6;
    localparam logic [5:0]  HaltOpcDefault  = 6'h3F;
    localparam logic [1:0]  FpuClassDefault = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StDecode,
        StIssue,
        StWait,
        StHalt
    } seq_state_e;

endpackage

// File: rtl/fetch_sequencer_pc_next_unit.sv
// Next-PC selection: branch redirect or sequential increment, wrapping modulo 2^PC_W.
module fetch_sequencer_pc_next_unit #(
    parameter int unsigned PC_W = 16
) (
    input  logic [PC_W-1:0] pc,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] pc_next
);

    logic [PC_W-1:0] pc_inc;

    // Carry out of the top bit is dropped, giving the wrap to zero.
    assign pc_inc  = pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign pc_next = branch_taken ? branch_target : pc_inc;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/issue control FSM: drives the PC and IR load, issues to integer or FPU execute,
// and advances or redirects the PC once execution completes.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned      PC_W      = PcWDefault,
    parameter int unsigned      OPC_W     = OpcWDefault,
    parameter logic [PC_W-1:0]  RESET_PC  = '0,
    parameter logic [OPC_W-1:0] HALT_OPC  = HaltOpcDefault,
    parameter logic [1:0]       FPU_CLASS = FpuClassDefault
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic [OPC_W-1:0] ir_opcode,
    input  logic             exec_ready,
    input  logic             exec_done,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    output logic [PC_W-1:0]  program_counter,
    output logic             loadIR,
    output logic             issue_valid,
    output logic             issue_fpu,
    output logic             busy,
    output logic             halted
);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_next;
    logic            fpu_q, fpu_d;
    logic            pc_update;

    fetch_sequencer_pc_next_unit #(
        .PC_W (PC_W)
    ) u_pc_next (
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_next       (pc_next)
    );

    always_comb begin
        state_d   = state_q;
        fpu_d     = fpu_q;
        pc_update = 1'b0;
        case (state_q)
            StIdle:   if (start) state_d = StFetch;
            StFetch:  state_d = StLoad;
            StLoad:   state_d = StDecode;
            StDecode: begin
                // A halt opcode leaves the PC on itself so resume refetches it.
                if (ir_opcode == HALT_OPC) begin
                    state_d = StHalt;
                end else begin
                    fpu_d   = (ir_opcode[OPC_W-1 -: 2] == FPU_CLASS);
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (exec_ready) begin
                    if (fpu_q) begin
                        state_d = StWait;
                    end else begin
                        pc_update = 1'b1;
                        state_d   = stop ? StHalt : StFetch;
                    end
                end
            end
            StWait: begin
                if (exec_done) begin
                    pc_update = 1'b1;
                    state_d   = stop ? StHalt : StFetch;
                end
            end
            StHalt:   if (start) state_d = StFetch;
            default:  state_d = StIdle;
        endcase
        pc_d = pc_update ? pc_next : pc_q;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            fpu_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fpu_q   <= fpu_d;
        end
    end

    assign program_counter = pc_q;
    assign loadIR          = (state_q == StLoad);
    assign issue_valid     = (state_q == StIssue);
    assign issue_fpu       = (state_q == StIssue) && fpu_q;
    assign busy            = (state_q != StIdle) && (state_q != StHalt);
    assign halted          = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table, directed corner sequences and
// randomized stimulus against a cycle-level reference model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [5:0]  ir_opcode = 6'h01;
    logic        exec_ready = 1'b0;
    logic        exec_done = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0;
    logic [15:0] program_counter;
    logic        loadIR, issue_valid, issue_fpu, busy, halted;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase 0 idle, 1 fetch, 2 load, 3 decode, 4 issue, 5 fpu wait, 6 halt.
    int m_phase = 0;
    int m_pc = 0;
    bit m_fpu = 1'b0;

    fetch_sequencer dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .stop            (stop),
        .ir_opcode       (ir_opcode),
        .exec_ready      (exec_ready),
        .exec_done       (exec_done),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .program_counter (program_counter),
        .loadIR          (loadIR),
        .issue_valid     (issue_valid),
        .issue_fpu       (issue_fpu),
        .busy            (busy),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        st;
        logic [5:0]  opc;
        logic [15:0] e_pc;
        logic [4:0]  e_flags; // {loadIR, issue_valid, issue_fpu, busy, halted}
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [4:0] dut_flags();
        return {loadIR, issue_valid, issue_fpu, busy, halted};
    endfunction

    task automatic retire();
        if (branch_taken) m_pc = int'(branch_target);
        else m_pc = (m_pc + 1) % 65536;
        m_phase = stop ? 6 : 1;
    endtask

    task automatic model_step();
        if (rstn) begin
            m_phase = 0;
            m_pc    = 0;
            m_fpu   = 1'b0;
        end else begin
            case (m_phase)
                0: if (start) m_phase = 1;
                1: m_phase = 2;
                2: m_phase = 3;
                3: begin
                    if (ir_opcode == 6'h3F) m_phase = 6;
                    else begin
                        m_fpu   = (int'(ir_opcode) / 16) == 2;
                        m_phase = 4;
                    end
                end
                4: if (exec_ready) begin
                    if (m_fpu) m_phase = 5;
                    else retire();
                end
                5: if (exec_done) retire();
                6: if (start) m_phase = 1;
                default: m_phase = 0;
            endcase
        end
    endtask

    function automatic logic [4:0] model_flags();
        logic [4:0] f;
        f[4] = (m_phase == 2);
        f[3] = (m_phase == 4);
        f[2] = (m_phase == 4) && m_fpu;
        f[1] = (m_phase != 0) && (m_phase != 6);
        f[0] = (m_phase == 6);
        return f;
    endfunction

    // Advance one clock with current inputs and compare against the model.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("pc", 32'(program_counter), 32'(m_pc));
        check("flags", 32'(dut_flags()), 32'(model_flags()));
    endtask

    task automatic quiet_inputs();
        rstn = 1'b0; start = 1'b0; stop = 1'b0; ir_opcode = 6'h01;
        exec_ready = 1'b0; exec_done = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One single-cycle instruction starting in FETCH with exec_ready already high.
    task automatic run_instr(input logic [5:0] opc, input logic br, input logic [15:0] tgt,
                             input logic stp);
        ir_opcode = opc; exec_ready = 1'b1; branch_taken = br; branch_target = tgt; stop = stp;
        for (int i = 0; i < 4; i++) tick();
        branch_taken = 1'b0; stop = 1'b0;
    endtask

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 6'h01, 16'd0, 5'b00000};
        vecs[1]  = '{1'b0, 1'b1, 6'h01, 16'd0, 5'b00010};
        vecs[2]  = '{1'b0, 1'b0, 6'h01, 16'd0, 5'b10010};
        vecs[3]  = '{1'b0, 1'b0, 6'h01, 16'd0, 5'b00010};
        vecs[4]  = '{1'b0, 1'b0, 6'h01, 16'd0, 5'b01010};
        vecs[5]  = '{1'b0, 1'b0, 6'h01, 16'd1, 5'b00010};
        vecs[6]  = '{1'b0, 1'b0, 6'h01, 16'd1, 5'b10010};
        vecs[7]  = '{1'b0, 1'b0, 6'h01, 16'd1, 5'b00010};
        vecs[8]  = '{1'b0, 1'b0, 6'h01, 16'd1, 5'b01010};
        vecs[9]  = '{1'b0, 1'b0, 6'h01, 16'd2, 5'b00010};
        vecs[10] = '{1'b0, 1'b0, 6'h01, 16'd2, 5'b10010};
        vecs[11] = '{1'b0, 1'b0, 6'h01, 16'd2, 5'b00010};
        vecs[12] = '{1'b0, 1'b0, 6'h01, 16'd2, 5'b01010};
        vecs[13] = '{1'b0, 1'b0, 6'h01, 16'd3, 5'b00010};
        vecs[14] = '{1'b0, 1'b0, 6'h01, 16'd3, 5'b10010};
        vecs[15] = '{1'b0, 1'b0, 6'h01, 16'd3, 5'b00010};
        vecs[16] = '{1'b0, 1'b0, 6'h3F, 16'd3, 5'b00001};
        vecs[17] = '{1'b0, 1'b1, 6'h01, 16'd3, 5'b00010};

        // Straight-line run of three instructions, then a halt opcode and resume.
        quiet_inputs();
        exec_ready = 1'b1;
        foreach (vecs[i]) begin
            rstn = vecs[i].rst; start = vecs[i].st; ir_opcode = vecs[i].opc;
            tick();
            check($sformatf("tbl%0d_pc", i), 32'(program_counter), 32'(vecs[i].e_pc));
            check($sformatf("tbl%0d_flags", i), 32'(dut_flags()), 32'(vecs[i].e_flags));
        end

        // Reset during FPU wait.
        do_reset();
        go();
        tick(); tick();
        ir_opcode = 6'h21; exec_ready = 1'b1;
        tick();
        check("fpu_issue", 32'(issue_fpu), 32'd1);
        tick();
        check("wait_no_issue", 32'(issue_valid), 32'd0);
        tick(); tick();
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        check("rst_wait_pc", 32'(program_counter), 32'd0);
        check("rst_wait_flags", 32'(dut_flags()), 32'd0);

        // FPU op, exec_done seven edges after the handshake.
        do_reset();
        go();
        tick(); tick();
        ir_opcode = 6'h21; exec_ready = 1'b1;
        tick();
        tick();
        exec_ready = 1'b0;
        check("fpu_one_cycle", 32'(issue_fpu), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("fpu_pc_hold", 32'(program_counter), 32'd0);
        end
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        check("fpu_done_pc", 32'(program_counter), 32'd1);
        check("fpu_done_busy", 32'(busy), 32'd1);

        // Branch redirect and wrap at the top of the address space.
        do_reset();
        go();
        run_instr(6'h01, 1'b1, 16'd5, 1'b0);
        check("br_to5", 32'(program_counter), 32'd5);
        run_instr(6'h01, 1'b1, 16'h0040, 1'b0);
        check("br_to40", 32'(program_counter), 32'h40);
        run_instr(6'h01, 1'b1, 16'hFFFF, 1'b0);
        run_instr(6'h01, 1'b0, 16'h1234, 1'b0);
        check("wrap", 32'(program_counter), 32'd0);

        // Halt opcode at PC 9, then resume refetches it.
        do_reset();
        go();
        run_instr(6'h01, 1'b1, 16'd9, 1'b0);
        run_instr(6'h3F, 1'b0, 16'd0, 1'b0);
        check("halt_pc", 32'(program_counter), 32'd9);
        check("halt_flags", 32'(dut_flags()), 32'b00001);
        go();
        check("resume_pc", 32'(program_counter), 32'd9);
        check("resume_busy", 32'(busy), 32'd1);

        // Stop while exec_ready is held low at PC 2.
        do_reset();
        go();
        run_instr(6'h01, 1'b1, 16'd2, 1'b0);
        stop = 1'b1; exec_ready = 1'b0; ir_opcode = 6'h01;
        tick(); tick(); tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 32'(issue_valid), 32'd1);
            check("stall_pc", 32'(program_counter), 32'd2);
        end
        exec_ready = 1'b1;
        tick();
        check("stop_pc", 32'(program_counter), 32'd3);
        check("stop_halted", 32'(halted), 32'd1);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rstn          = ($urandom_range(0, 99) == 0);
            start         = ($urandom_range(0, 3) == 0);
            stop          = ($urandom_range(0, 3) == 0);
            ir_opcode     = ($urandom_range(0, 7) == 0) ? 6'h3F : 6'($urandom);
            exec_ready    = $urandom_range(0, 1) == 1;
            exec_done     = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 3) == 0);
            branch_target = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
